// File: rtl/alu_flag_stage_pkg.sv
// Shared definitions for the ALU flag stage: flag bit positions and helpers.
// Optional overflow flag is enabled by defining ALU_FLAG_OVF_EN.
package alu_flag_stage_pkg;

    localparam int FLAGS_W = 4;
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;

    typedef logic [FLAGS_W-1:0] flags_t;

    // Pointer width for a FIFO of n entries, never below one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational NZCV flag derivation from the adder result.
// V is computed only when ALU_FLAG_OVF_EN is defined, otherwise tied to 0.
module alu_flag_calc
    import alu_flag_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_s,
    input  logic             i_c_out,
    output flags_t           o_flags
);

`ifdef ALU_FLAG_OVF_EN
    logic w_v;
    assign w_v = (i_a[WIDTH-1] == i_b[WIDTH-1])
               & (i_s[WIDTH-1] != i_a[WIDTH-1]);
`else
    logic w_v;
    logic w_unused_ab;
    assign w_v         = 1'b0;
    assign w_unused_ab = ^{i_a, i_b};
`endif

    // Assemble the flag nibble from the sum, carry and overflow.
    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = i_s[WIDTH-1];
        o_flags[FLAG_Z] = (i_s == '0);
        o_flags[FLAG_C] = i_c_out;
        o_flags[FLAG_V] = w_v;
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered flag stage behind the 32-bit adder: small FIFO, sticky flags,
// retired-result counter. Define ALU_FLAG_OVF_EN to enable the V flag.
module alu_flag_stage
    import alu_flag_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] s_in,
    input  logic             c_out_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_q,
    output flags_t           flags_q,
    output flags_t           sticky_flags,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] result_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem_s [DEPTH];
    flags_t           r_mem_f [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last_s;
    flags_t           r_last_f;
    flags_t           r_sticky;
    logic [CNT_W-1:0] r_res_cnt;

    flags_t           w_flags;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_s;
    flags_t           w_head_f;

    alu_flag_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .i_a     (a_in),
        .i_b     (b_in),
        .i_s     (s_in),
        .i_c_out (c_out_in),
        .o_flags (w_flags)
    );

    // Ready and valid come from registered occupancy only.
    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_head_s  = r_mem_s[r_rd_ptr];
    assign w_head_f  = r_mem_f[r_rd_ptr];

    // Head is shown while valid; the last popped value is held when empty.
    assign s_q          = out_valid ? w_head_s : r_last_s;
    assign flags_q      = out_valid ? w_head_f : r_last_f;
    assign sticky_flags = r_sticky;
    assign result_count = r_res_cnt;

    // Storage array; contents are qualified by occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_s[r_wr_ptr] <= s_in;
            r_mem_f[r_wr_ptr] <= w_flags;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    // Hold value, sticky flags and retired-result counter, updated on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_s  <= '0;
            r_last_f  <= '0;
            r_sticky  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_last_s  <= w_head_s;
                r_last_f  <= w_head_f;
                r_res_cnt <= r_res_cnt + CNT_W'(1);
                r_sticky  <= clr_sticky ? w_head_f
                                        : (r_sticky | w_head_f);
            end else if (clr_sticky) begin
                r_sticky <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Self-checking bench for alu_flag_stage: directed steps plus random traffic
// against a queue-based reference model. Uses a 4-bit result counter.
module tb_alu_flag_stage;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic [W-1:0]  s_in = '0;
    logic          c_out_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  s_q;
    logic [3:0]    flags_q;
    logic [3:0]    sticky_flags;
    logic          clr_sticky = 1'b0;
    logic [CW-1:0] result_count;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q_s [$];
    logic [3:0]   q_f [$];
    logic [3:0]   m_sticky;
    int           m_cnt;
    logic [W-1:0] m_last_s;
    logic [3:0]   m_last_f;

    always #5 clk = ~clk;

    alu_flag_stage #(
        .WIDTH (W),
        .DEPTH (D),
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .s_in         (s_in),
        .c_out_in     (c_out_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .s_q          (s_q),
        .flags_q      (flags_q),
        .sticky_flags (sticky_flags),
        .clr_sticky   (clr_sticky),
        .result_count (result_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags from arithmetic meaning: sign, zero, carry, signed overflow.
    function automatic logic [3:0] ref_flags(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] s,
                                             input logic c);
        logic n, z, v;
        longint sa, sb, ss;
        n  = ($signed(s) < 0);
        z  = (s == 0);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ss = longint'($signed(s));
        v  = 1'b0;
`ifdef ALU_FLAG_OVF_EN
        v  = ((sa + sb) != ss);
`endif
        return {n, z, c, v};
    endfunction

    task automatic model_reset();
        q_s.delete();
        q_f.delete();
        m_sticky = '0;
        m_cnt    = 0;
        m_last_s = '0;
        m_last_f = '0;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q_s.size() > 0));
        chk({tag, ".s_q"}, s_q, (q_s.size() > 0) ? q_s[0] : m_last_s);
        chk({tag, ".flags_q"}, 32'(flags_q),
            32'((q_f.size() > 0) ? q_f[0] : m_last_f));
        chk({tag, ".sticky"}, 32'(sticky_flags), 32'(m_sticky));
        chk({tag, ".count"}, 32'(result_count), 32'(m_cnt));
    endtask

    // One clock: drive, check ready, clock, update model, check outputs.
    task automatic cyc(input string tag, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy, input logic clr);
        logic [W:0] sum;
        logic       push, pop;
        logic [3:0] f;
        sum        = {1'b0, a} + {1'b0, b};
        in_valid   = v;
        a_in       = a;
        b_in       = b;
        s_in       = sum[W-1:0];
        c_out_in   = sum[W];
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q_s.size() < D));
        push = v && (q_s.size() < D);
        pop  = ordy && (q_s.size() > 0);
        f    = ref_flags(a, b, sum[W-1:0], sum[W]);
        @(posedge clk);
        if (pop) begin
            m_last_s = q_s.pop_front();
            m_last_f = q_f.pop_front();
            m_sticky = clr ? m_last_f : (m_sticky | m_last_f);
            m_cnt    = (m_cnt + 1) % (1 << CW);
        end else if (clr) begin
            m_sticky = '0;
        end
        if (push) begin
            q_s.push_back(sum[W-1:0]);
            q_f.push_back(f);
        end
        #1;
        check_out(tag);
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        check_out("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int sel;
        model_reset();

        // Reset state
        do_reset();

        // 1: 1+1 = 2
        cyc("t1_push", 1, 32'd1, 32'd1, 1, 0);
        chk("t1.s_q", s_q, 32'd2);
        chk("t1.flags", 32'(flags_q), 32'b0000);
        cyc("t1_pop", 0, 0, 0, 1, 0);

        // 2: negative then zero
        do_reset();
        cyc("t2_neg", 1, 32'h0, 32'hFFFF_FFFF, 0, 0);
        chk("t2.neg_flags", 32'(flags_q), 32'b1000);
        cyc("t2_zero", 1, 32'h0, 32'h0, 1, 0);
        chk("t2.zero_flags", 32'(flags_q), 32'b0100);
        cyc("t2_drain", 0, 0, 0, 1, 0);
        chk("t2.sticky", 32'(sticky_flags), 32'b1100);
        chk("t2.count", 32'(result_count), 32'd2);

        // 3: carry, and signed overflow
        cyc("t3_carry", 1, 32'd3, 32'hFFFF_FFFF, 1, 0);
        chk("t3.carry_s", s_q, 32'd2);
        chk("t3.carry_flags", 32'(flags_q), 32'b0010);
        cyc("t3_ovf", 1, 32'h7FFF_FFFF, 32'd1, 1, 0);
`ifdef ALU_FLAG_OVF_EN
        chk("t3.ovf_flags", 32'(flags_q), 32'b1001);
`else
        chk("t3.ovf_flags", 32'(flags_q), 32'b1000);
`endif
        cyc("t3_drain", 0, 0, 0, 1, 0);

        // 4: backpressure, full FIFO blocks push even with a pop
        cyc("t4_p1", 1, 32'd10, 32'd1, 0, 0);
        cyc("t4_p2", 1, 32'd20, 32'd2, 0, 0);
        chk("t4.full_ready", 32'(in_ready), 32'd0);
        cyc("t4_hold", 1, 32'd30, 32'd3, 0, 0);
        cyc("t4_pop1", 1, 32'd30, 32'd3, 1, 0);
        chk("t4.pop1_head", s_q, 32'd22);
        cyc("t4_pp", 1, 32'd30, 32'd3, 1, 0);
        chk("t4.pp_head", s_q, 32'd33);
        cyc("t4_pop3", 0, 0, 0, 1, 0);
        chk("t4.last_hold", s_q, 32'd33);
        chk("t4.empty", 32'(out_valid), 32'd0);

        // 5: asynchronous reset while holding two entries
        cyc("t5_p1", 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        cyc("t5_p2", 1, 32'd5, 32'd6, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.out_valid", 32'(out_valid), 32'd0);
        chk("t5.count", 32'(result_count), 32'd0);
        chk("t5.sticky", 32'(sticky_flags), 32'd0);
        chk("t5.in_ready", 32'(in_ready), 32'd1);
        chk("t5.s_q", s_q, 32'd0);
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("t5_idle", 0, 0, 0, 1, 0);

        // 6: counter wrap, then clear-with-pop of a zero entry
        for (int i = 0; i < 40 && m_cnt != 15; i++)
            cyc("t6_fill", 1, $urandom, $urandom, 1, 0);
        chk("t6.at15", 32'(result_count), 32'd15);
        cyc("t6_wrap", 1, 32'h0, 32'h0, 1, 0);
        chk("t6.wrap0", 32'(result_count), 32'd0);
        cyc("t6_clrpop", 0, 0, 0, 1, 1);
        chk("t6.sticky_z", 32'(sticky_flags), 32'b0100);
        cyc("t6_clr", 0, 0, 0, 0, 1);
        chk("t6.sticky_0", 32'(sticky_flags), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 4));
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = -ra;
            if (sel == 1) begin
                ra = {1'b0, ra[W-2:0]};
                rb = {1'b0, rb[W-2:0]};
            end
            if (sel == 2) begin
                ra = {1'b1, ra[W-2:0]};
                rb = {1'b1, rb[W-2:0]};
            end
            cyc("rnd", 1'($urandom_range(0, 1)), ra, rb,
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
